// File: rtl/regfile_sb.sv
// regfile_sb: 32-entry integer register file with a per-register busy
// scoreboard. Two combinational read ports with same-cycle write-back
// bypass, one write-back port, and an issue port that marks a destination
// busy until its write-back arrives. stall_o flags a read whose source is
// still owed by an in-flight producer.

`ifndef RDATA_WIDTH
`define RDATA_WIDTH 32
`endif
`ifndef RADDR_WIDTH
`define RADDR_WIDTH 5
`endif

module regfile_sb (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [`RADDR_WIDTH-1:0] reg1_raddr_i,
   input  logic                    reg1_re_i,
   input  logic [`RADDR_WIDTH-1:0] reg2_raddr_i,
   input  logic                    reg2_re_i,
   output logic [`RDATA_WIDTH-1:0] reg1_rdata_o,
   output logic [`RDATA_WIDTH-1:0] reg2_rdata_o,
   input  logic                    we_i,
   input  logic [`RADDR_WIDTH-1:0] waddr_i,
   input  logic [`RDATA_WIDTH-1:0] wdata_i,
   input  logic                    issue_i,
   input  logic [`RADDR_WIDTH-1:0] issue_waddr_i,
   output logic                    stall_o,
   output logic [31:0]             pending_o
);

   localparam int NUM_RD = 2;

   logic [`RDATA_WIDTH-1:0] regs [32];
   logic [31:0]             busy;
   logic [31:0]             wr_hit;
   logic [31:0]             iss_hit;

   logic [NUM_RD-1:0][`RADDR_WIDTH-1:0] rd_addr;
   logic [NUM_RD-1:0]                   rd_en;
   logic [NUM_RD-1:0][`RDATA_WIDTH-1:0] rd_data;
   logic [NUM_RD-1:0]                   rd_blk;

   // One-hot decode of write-back and issue targets; bit 0 never hits
   always_comb begin
      wr_hit  = '0;
      iss_hit = '0;
      if (we_i)    wr_hit  = 32'b1 << waddr_i;
      if (issue_i) iss_hit = 32'b1 << issue_waddr_i;
      wr_hit[0]  = 1'b0;
      iss_hit[0] = 1'b0;
   end

   // Register storage; x0 is held at zero so every entry has a driver
   always_ff @(posedge clk) begin
      for (int i = 0; i < 32; i++) begin
         if (!rst_n || i == 0)
            regs[i] <= '0;
         else if (wr_hit[i])
            regs[i] <= wdata_i;
      end
   end

   // Scoreboard: write-back clears, issue sets, a new issue beats a retiring write
   always_ff @(posedge clk) begin
      if (!rst_n)
         busy <= '0;
      else
         busy <= (busy & ~wr_hit) | iss_hit;
   end

   assign rd_addr   = {reg2_raddr_i, reg1_raddr_i};
   assign rd_en     = {reg2_re_i, reg1_re_i};
   assign reg1_rdata_o = rd_data[0];
   assign reg2_rdata_o = rd_data[1];

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic bypass;
      assign bypass = we_i && (waddr_i == rd_addr[p]) && (rd_addr[p] != '0);

      // Read mux with same-cycle write-back forwarding and hazard detect
      always_comb begin
         rd_data[p] = '0;
         rd_blk[p]  = 1'b0;
         if (rd_en[p] && rd_addr[p] != '0) begin
            rd_data[p] = bypass ? wdata_i : regs[rd_addr[p]];
            rd_blk[p]  = busy[rd_addr[p]] && !bypass;
         end
      end
   end

   assign stall_o   = |rd_blk;
   assign pending_o = busy;

endmodule
